// File: rtl/dyn_branch_predict.sv
// dyn_branch_predict: PHT of 2-bit counters (bimodal or gshare) with a speculative,
// checkpoint-repaired global history and resolved/mispredicted branch counters.
module dyn_branch_predict #(
   parameter int IDX_W = 8,
   parameter int GHR_W = 8,
   parameter int MODE  = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallD,
   input  logic             flushD,
   input  logic [31:0]      pcD,
   input  logic             branchD,
   output logic             pred_takeD,
   output logic [IDX_W-1:0] pht_idxD,
   output logic [GHR_W-1:0] ghr_snapD,
   input  logic             update_enM,
   input  logic [IDX_W-1:0] pht_idxM,
   input  logic [GHR_W-1:0] ghr_snapM,
   input  logic             actual_takeM,
   input  logic             mispredM,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);
   localparam int N = 2 ** IDX_W;

   if (GHR_W < 1 || GHR_W > IDX_W || MODE < 0 || MODE > 1) begin : g_bad_param
      $fatal(1, "dyn_branch_predict: illegal MODE or GHR_W");
   end

   logic [1:0]       pht_q [N];
   logic [1:0]       pht_d [N];
   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
   logic [1:0]       ctr_m;
   logic             unused_pc;

   assign unused_pc   = ^{pcD[31:IDX_W+2], pcD[1:0]};
   assign pht_idxD    = pcD[IDX_W+1:2] ^ (MODE == 1 ? IDX_W'(ghr_q) : '0);
   assign pred_takeD  = branchD & pht_q[pht_idxD][1];
   assign ghr_snapD   = ghr_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

   // A resolved mispredict restores the checkpoint and overrides the wrong-path D shift.
   always_comb begin
      ctr_m = pht_q[pht_idxM];
      pht_d = pht_q;
      if (update_enM)
         pht_d[pht_idxM] = actual_takeM ? (ctr_m == 2'b11 ? ctr_m : ctr_m + 2'd1)
                                        : (ctr_m == 2'b00 ? ctr_m : ctr_m - 2'd1);
      ghr_d = (update_enM & mispredM)        ? GHR_W'({ghr_snapM, actual_takeM}) :
              (branchD & ~stallD & ~flushD) ? GHR_W'({ghr_q, pred_takeD}) : ghr_q;
      branch_cnt_d  = branch_cnt_q + CNT_W'(update_enM);
      mispred_cnt_d = mispred_cnt_q + CNT_W'(update_enM & mispredM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) pht_q[i] <= 2'b01;
         ghr_q         <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pht_q         <= pht_d;
         ghr_q         <= ghr_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
endmodule

// File: tb/tb_dyn_branch_predict.sv
// tb_dyn_branch_predict: directed vectors for a bimodal (CNT_W=4) and a gshare (GHR_W=4) instance.
module tb_dyn_branch_predict;
   logic        clk = 0, rst = 1, stallD = 0, flushD = 0, branchD = 0;
   logic [31:0] pcD = 32'h100;
   logic        update_enM = 0, actual_takeM = 0, mispredM = 0;
   logic [7:0]  pht_idxM = 0, ghr_snapM0 = 0;
   logic [3:0]  ghr_snapM1 = 0;
   logic        pred0, pred1;
   logic [7:0]  idx0, idx1, snap0;
   logic [3:0]  snap1, bc0, mc0;
   logic [31:0] bc1, mc1;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   dyn_branch_predict #(.IDX_W(8), .GHR_W(8), .MODE(0), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcD(pcD), .branchD(branchD),
      .pred_takeD(pred0), .pht_idxD(idx0), .ghr_snapD(snap0), .update_enM(update_enM),
      .pht_idxM(pht_idxM), .ghr_snapM(ghr_snapM0), .actual_takeM(actual_takeM),
      .mispredM(mispredM), .branch_cnt(bc0), .mispred_cnt(mc0));

   dyn_branch_predict #(.IDX_W(8), .GHR_W(4), .MODE(1), .CNT_W(32)) u1 (
      .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcD(pcD), .branchD(branchD),
      .pred_takeD(pred1), .pht_idxD(idx1), .ghr_snapD(snap1), .update_enM(update_enM),
      .pht_idxM(pht_idxM), .ghr_snapM(ghr_snapM1), .actual_takeM(actual_takeM),
      .mispredM(mispredM), .branch_cnt(bc1), .mispred_cnt(mc1));

   typedef struct {
      logic       upd, act, mis, exp_pred;
      logic [3:0] exp_bc, exp_mc;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      // training of idx 0x40 from 01: up/down with saturation, upd=0 row is ignored
      tbl[0] = '{1, 1, 0, 1, 1, 0};
      tbl[1] = '{1, 1, 1, 1, 2, 1};
      tbl[2] = '{1, 1, 0, 1, 3, 1};
      tbl[3] = '{1, 0, 1, 1, 4, 2};
      tbl[4] = '{1, 0, 0, 0, 5, 2};
      tbl[5] = '{1, 0, 0, 0, 6, 2};
      tbl[6] = '{1, 0, 1, 0, 7, 3};
      tbl[7] = '{0, 0, 1, 0, 7, 3};
      tbl[8] = '{1, 1, 0, 0, 8, 3};
      tbl[9] = '{1, 1, 0, 1, 9, 3};

      branchD = 1;
      #2;
      chk("reset_pred", pred0, 0);
      chk("reset_idx", idx0, 8'h40);
      chk("reset_snap", snap0, 0);
      chk("reset_bc", bc0, 0);
      tick();
      rst = 0;

      stallD = 1;
      pht_idxM = 8'h40;
      for (int i = 0; i < 10; i++) begin
         update_enM = tbl[i].upd;
         actual_takeM = tbl[i].act;
         mispredM = tbl[i].mis;
         tick();
         update_enM = 0;
         mispredM = 0;
         #1;
         chk($sformatf("tbl%0d_pred", i), pred0, tbl[i].exp_pred);
         chk($sformatf("tbl%0d_idx", i), idx0, 8'h40);
         chk($sformatf("tbl%0d_bc", i), bc0, tbl[i].exp_bc);
         chk($sformatf("tbl%0d_mc", i), mc0, tbl[i].exp_mc);
      end

      pulse_rst();
      update_enM = 1;
      actual_takeM = 1;
      #1;
      chk("same_cycle_pred_old", pred0, 0);
      tick();
      update_enM = 0;
      #1;
      chk("same_cycle_pred_new", pred0, 1);

      pulse_rst();
      for (int i = 0; i < 16; i++) begin
         update_enM = 1;
         actual_takeM = 1;
         mispredM = (i < 5);
         tick();
      end
      update_enM = 0;
      mispredM = 0;
      #1;
      chk("wrap_bc", bc0, 0);
      chk("wrap_mc", mc0, 5);
      chk("wrap_pred", pred0, 1);
      rst = 1;
      #1;
      chk("async_rst_bc", bc0, 0);
      chk("async_rst_mc", mc0, 0);
      chk("async_rst_pred", pred0, 0);
      tick();
      rst = 0;

      pulse_rst();
      stallD = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("gs_pred%0d", i), pred1, 0);
         chk($sformatf("gs_snap%0d", i), snap1, 0);
         tick();
      end
      chk("gs_snap_after3", snap1, 0);
      update_enM = 1;
      mispredM = 1;
      actual_takeM = 1;
      ghr_snapM1 = 4'b0101;
      pht_idxM = 8'h10;
      tick();
      update_enM = 0;
      mispredM = 0;
      stallD = 1;
      #1;
      chk("repair_snap", snap1, 4'b1011);
      chk("repair_idx", idx1, 8'h4B);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall_snap%0d", i), snap1, 4'b1011);
      end
      stallD = 0;
      flushD = 1;
      tick();
      chk("flush_snap", snap1, 4'b1011);
      flushD = 0;
      branchD = 0;
      update_enM = 1;
      actual_takeM = 1;
      pht_idxM = 8'h4B;
      tick();
      tick();
      update_enM = 0;
      branchD = 1;
      #1;
      chk("gs_pred_taken", pred1, 1);
      tick();
      chk("gs_shift_snap", snap1, 4'b0111);
      chk("gs_shift_idx", idx1, 8'h47);
      chk("gs_bc", bc1, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dyn_branch_predict.md
Name: dyn_branch_predict

Overview:
- Parametrised dynamic branch predictor. It replaces the static predictor used in the D stage of the 5-stage MIPS pipeline.
- Prediction is combinational in D, from a pattern history table (PHT) of 2-bit saturating counters, indexed bimodally or by gshare.
- A speculative global history register (GHR) is checkpointed per branch and repaired from M on a misprediction.
- Counters are trained in M. Perf counters track resolved branches and mispredictions.

Parameters:
- IDX_W, 8, PHT index width; the PHT has 2**IDX_W entries.
- GHR_W, 8, global history length; must satisfy 1 <= GHR_W <= IDX_W.
- MODE, 1, index mode: 0 = bimodal (PC only), 1 = gshare (PC xor GHR).
- CNT_W, 32, width of each perf counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stallD  in  1  D stage stalled
- flushD  in  1  D stage instruction invalid
- pcD  in  32  PC of the D-stage instruction
- branchD  in  1  D-stage instruction is a conditional branch
- pred_takeD  out  1  predicted taken
- pht_idxD  out  IDX_W  PHT index used; the datapath pipelines it to M
- ghr_snapD  out  GHR_W  GHR value before this branch's speculative shift; pipelined to M
- update_enM  in  1  M-stage branch resolved this cycle (already qualified with ~stallM)
- pht_idxM  in  IDX_W  pipelined pht_idxD
- ghr_snapM  in  GHR_W  pipelined ghr_snapD
- actual_takeM  in  1  resolved direction
- mispredM  in  1  pred_takeM != actual_takeM
- branch_cnt  out  CNT_W  number of resolved branches
- mispred_cnt  out  CNT_W  number of mispredictions

Behaviour:
- Reset:
  - Asynchronous, no clock needed.
  - Every PHT entry becomes 2'b01 (weakly not-taken). GHR becomes 0. Both perf counters become 0.
  - Consequently pred_takeD = 0 from the reset instant, for any branch.
- Index:
  - MODE=0: idx = pcD[IDX_W+1:2].
  - MODE=1: idx = pcD[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}.
  - pht_idxD = idx; ghr_snapD = ghr. Both are combinational and valid every cycle.
- Prediction:
  - pred_takeD = branchD & pht[idx][1], combinational, zero latency.
  - No bypass: an M update to the same index in the same cycle is not visible to D until the next cycle.
- Speculative GHR:
  - At the clock edge where branchD & ~stallD & ~flushD: ghr <= {ghr[GHR_W-2:0], pred_takeD}. For GHR_W=1: ghr <= pred_takeD.
  - The GHR does not change while the instruction is stalled or flushed.
- Repair:
  - At the clock edge where update_enM & mispredM: ghr <= {ghr_snapM[GHR_W-2:0], actual_takeM}.
  - Repair has priority over a same-cycle D speculative shift; that shift is discarded, because the D instruction is wrong-path.
- Training, at the clock edge where update_enM:
  - actual_takeM = 1: pht[pht_idxM] increments, saturating at 2'b11.
  - actual_takeM = 0: pht[pht_idxM] decrements, saturating at 2'b00.
  - Only one entry is written per cycle.
- Perf counters:
  - update_enM increments branch_cnt.
  - update_enM & mispredM increments mispred_cnt.
  - Both wrap modulo 2**CNT_W. Reads are registered values.
- Inputs are don't-care when their enable is low: branchD=0 ignores D, update_enM=0 ignores all M inputs.
- Exceptions: no explicit GHR repair. A flushed wrong-path branch that already shifted the GHR is tolerated, because it degrades accuracy only, never correctness.
- Reset asserted mid-operation clears all state immediately. Pending M updates are lost.
- MODE and GHR_W constraints are checked at elaboration; a violation is a fatal error.

Test Plan:
- Reset, then branchD=1, pcD=0x100 -> pred_takeD=0, pht_idxD=0x40 (MODE=0), ghr_snapD=0.
- MODE=0, train pht_idx 0x40 taken twice -> counter 01→10→11; pred_takeD=1 for pcD=0x100. A third taken update stays 11. Four not-taken updates saturate at 00.
- MODE=1, GHR_W=4, three unstalled predicted-not-taken branches -> ghr=0. Then update_enM, mispredM=1, ghr_snapM=4'b0101, actual_takeM=1 -> ghr=4'b1011 next cycle, ignoring a same-cycle branchD.
- branchD=1 with stallD=1 for 3 cycles, then flushD=1 -> GHR unchanged throughout.
- Same-cycle read and write of idx 0x40 (counter 01, update taken) -> pred_takeD=0 that cycle, 1 the next.
- CNT_W=4: 16 updates with mispredM on 5 of them -> branch_cnt=0 (wrapped), mispred_cnt=5. Assert rst mid-run -> all counters 0 and PHT entries 01 without waiting for a clock edge.
